// File: rtl/text_console_ctrl.sv
// Write-side controller for the text-mode character RAM: accepts a byte stream,
// tracks the cursor and sequences character writes plus line/screen clears.
module text_console_ctrl #(
    parameter int unsigned COLS      = 40,
    parameter int unsigned ROWS      = 15,
    parameter int unsigned ADDR_W    = 11,
    parameter logic [7:0]  FILL_CHAR = 8'h20
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] write_character_pos,
    output logic [7:0]        write_character,
    output logic              write_strobe,
    output logic [ADDR_W-1:0] cursor_pos,
    output logic              busy
);

    localparam int unsigned ColW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int unsigned RowW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int unsigned CntW = ADDR_W + 1;

    localparam logic [ColW-1:0]   ColLast  = ColW'(COLS - 1);
    localparam logic [ColW-1:0]   ColOne   = ColW'(1);
    localparam logic [RowW-1:0]   RowLast  = RowW'(ROWS - 1);
    localparam logic [RowW-1:0]   RowOne   = RowW'(1);
    localparam logic [CntW-1:0]   ColsCnt  = CntW'(COLS);
    localparam logic [CntW-1:0]   TotalCnt = CntW'(ROWS * COLS);
    localparam logic [CntW-1:0]   CntOne   = CntW'(1);
    localparam logic [ADDR_W-1:0] ColsAddr = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] AddrOne  = ADDR_W'(1);

    typedef enum logic [1:0] {
        StIdle,
        StClearLine,
        StClearAll
    } state_e;

    state_e            state_q;
    logic [ColW-1:0]   col_q;
    logic [RowW-1:0]   row_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] cursor_q;
    logic [ADDR_W-1:0] wpos_q;
    logic [7:0]        wchar_q;
    logic              wstrobe_q;
    logic [CntW-1:0]   cnt_q;

    logic [RowW-1:0]   row_adv;
    logic [ADDR_W-1:0] base_adv;
    logic              accept;
    logic              printable;

    // Row base tracks row*COLS so no multiplier is needed; it wraps with the row.
    always_comb begin
        if (row_q == RowLast) begin
            row_adv  = '0;
            base_adv = '0;
        end else begin
            row_adv  = row_q + RowOne;
            base_adv = base_q + ColsAddr;
        end
    end

    assign in_ready  = (state_q == StIdle) && !reset;
    assign busy      = (state_q != StIdle) || reset;
    assign accept    = in_valid && in_ready;
    assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

    assign write_character_pos = wpos_q;
    assign write_character     = wchar_q;
    assign write_strobe        = wstrobe_q;
    assign cursor_pos          = cursor_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= StClearAll;
            col_q     <= '0;
            row_q     <= '0;
            base_q    <= '0;
            cursor_q  <= '0;
            wpos_q    <= '0;
            wchar_q   <= '0;
            wstrobe_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            wstrobe_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        if (printable) begin
                            wstrobe_q <= 1'b1;
                            wpos_q    <= cursor_q;
                            wchar_q   <= in_data;
                            if (col_q == ColLast) begin
                                col_q    <= '0;
                                row_q    <= row_adv;
                                base_q   <= base_adv;
                                cursor_q <= base_adv;
                                cnt_q    <= '0;
                                state_q  <= StClearLine;
                            end else begin
                                col_q    <= col_q + ColOne;
                                cursor_q <= cursor_q + AddrOne;
                            end
                        end else begin
                            case (in_data)
                                8'h0A: begin
                                    col_q    <= '0;
                                    row_q    <= row_adv;
                                    base_q   <= base_adv;
                                    cursor_q <= base_adv;
                                    cnt_q    <= '0;
                                    state_q  <= StClearLine;
                                end
                                8'h0D: begin
                                    col_q    <= '0;
                                    cursor_q <= base_q;
                                end
                                8'h08: begin
                                    if (col_q != '0) begin
                                        col_q     <= col_q - ColOne;
                                        cursor_q  <= cursor_q - AddrOne;
                                        wstrobe_q <= 1'b1;
                                        wpos_q    <= cursor_q - AddrOne;
                                        wchar_q   <= FILL_CHAR;
                                    end
                                end
                                8'h0C: begin
                                    col_q    <= '0;
                                    row_q    <= '0;
                                    base_q   <= '0;
                                    cursor_q <= '0;
                                    cnt_q    <= '0;
                                    state_q  <= StClearAll;
                                end
                                default: begin
                                end
                            endcase
                        end
                    end
                end
                StClearLine: begin
                    // One idle cycle after the final strobe before returning to StIdle.
                    if (cnt_q < ColsCnt) begin
                        wstrobe_q <= 1'b1;
                        wpos_q    <= base_q + cnt_q[ADDR_W-1:0];
                        wchar_q   <= FILL_CHAR;
                        cnt_q     <= cnt_q + CntOne;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StClearAll: begin
                    if (cnt_q < TotalCnt) begin
                        wstrobe_q <= 1'b1;
                        wpos_q    <= cnt_q[ADDR_W-1:0];
                        wchar_q   <= FILL_CHAR;
                        cnt_q     <= cnt_q + CntOne;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: doc/text_console_ctrl.md
Name: text_console_ctrl

Overview:
Write-side controller for the text-mode character RAM. It accepts a byte stream over a valid/ready handshake and maintains a cursor. It interprets a small set of control codes and sequences every write into the char_ram write port (write_character_pos / write_character / write_strobe), including multi-cycle line and screen clears. The display read port of char_ram is untouched; this block is the sole owner of the write port.

Parameters:
COLS, 40, characters per row
ROWS, 15, rows per screen
ADDR_W, 11, char_ram address width; ROWS*COLS <= 2**ADDR_W
FILL_CHAR, 8'h20, character written by clears and backspace

Ports:
CLK  input  1  system clock (pixel-domain PLL output)
reset  input  1  synchronous, active-high reset
in_data  input  8  byte to display or control code
in_valid  input  1  in_data valid
in_ready  output  1  block can accept a byte this cycle
write_character_pos  output  ADDR_W  char_ram write address
write_character  output  8  char_ram write data
write_strobe  output  1  char_ram write enable, one cycle per write
cursor_pos  output  ADDR_W  row*COLS+col of the current cursor
busy  output  1  clear sequence in progress

Behaviour:
- Reset is one clock and active-high. While reset is high: write_strobe=0, write_character_pos=0, write_character=0, cursor row=col=0, cursor_pos=0, in_ready=0, busy=1.
- After reset releases, the state is CLEAR_ALL.
- States:
  - IDLE: in_ready=1, busy=0.
  - CLEAR_LINE: in_ready=0, busy=1.
  - CLEAR_ALL: in_ready=0, busy=1.
- in_ready is combinational (state==IDLE). A byte is accepted on a cycle where in_valid && in_ready. in_data is ignored otherwise.
- All write-port outputs and cursor_pos are registered. The effect of an accepted byte appears on the following cycle.
- Row advance: row = (row==ROWS-1) ? 0 : row+1. There is no scrolling. The new row is always cleared via CLEAR_LINE.
- Byte decoding in IDLE:
  - 0x20..0x7E (printable):
    - Next cycle: write_strobe=1, pos=cursor, char=in_data.
    - col+1. If col was COLS-1: col=0, row advance, enter CLEAR_LINE.
  - 0x0A (LF): col=0, row advance, enter CLEAR_LINE. No write.
  - 0x0D (CR): col=0. No write. Stay in IDLE.
  - 0x08 (BS):
    - If col>0: col-1, and next cycle write FILL_CHAR at the new cursor.
    - If col==0: no change, no write.
  - 0x0C (FF): cursor to 0,0, enter CLEAR_ALL.
  - Any other value: consumed, no effect.
- CLEAR_LINE:
  - Starting the cycle after entry, writes FILL_CHAR to row*COLS+0 .. row*COLS+COLS-1, one per cycle (COLS consecutive strobes).
  - in_ready returns high the cycle after the last strobe.
- CLEAR_ALL:
  - Writes FILL_CHAR to addresses 0 .. ROWS*COLS-1, one per cycle, then IDLE.
  - Cursor holds 0.
- write_strobe is 0 in every cycle not listed above. write_character_pos/write_character hold their last value when the strobe is 0.
- cursor_pos updates the cycle after the cursor change and never exceeds ROWS*COLS-1.
- Arithmetic: row*COLS is computed without a runtime multiplier: keep a running row base (add/sub COLS, reset to 0 on wrap).
- Reset asserted mid-clear or mid-write aborts immediately to the reset values above, then performs a fresh full CLEAR_ALL.
- in_valid held high with no acceptance: the byte must be presented again and is not lost.

Test Plan:
- Reset released at cycle 0 -> write_strobe high for exactly ROWS*COLS=600 consecutive cycles at pos 0..599, all with char 0x20. in_ready rises on the cycle after pos 599. cursor_pos=0.
- Send 'A' (0x41), 'B' (0x42) back-to-back -> strobes at pos 0 char 0x41, then pos 1 char 0x42. cursor_pos=2. No other writes.
- Put the cursor at row 0 col 39 and send 'Z' -> write pos 39 char 0x5A. Then 40 strobes of 0x20 at pos 40..79. in_ready low throughout. cursor_pos=40.
- Put the cursor at row 14 col 5 and send 0x0A -> no character write. 40 clears at pos 0..39. cursor_pos=0.
- Send BS at col 0 -> no strobe, cursor unchanged. Send 'Q' then BS -> write pos 0 0x51, then pos 0 0x20. cursor_pos=0.
- Send 0x0C, then assert reset for 1 cycle mid-clear (at pos 300) -> outputs return to reset values. A new clear restarts from pos 0 and runs all 600 writes. in_valid bytes held during busy are accepted only after in_ready rises.
